// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester logic-ALU front-end:
// opcode encodings, controller state type and the per-bit ALU function.
package alu_share_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    function automatic logic alu_bit(input logic [1:0] op, input logic a, input logic b);
        logic y;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/alu_logic_core.sv
// Combinational bit-sliced logic ALU: each result bit is a 4-to-1 selection
// of AND/OR/XOR/NOT-A over the matching operand bits.
module alu_logic_core
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            y_o[i] = alu_bit(op_i, a_i[i], b_i[i]);
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin front-end sharing one logic ALU between two requesters, with a
// registered, tagged response channel and per-channel completion counters.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,

    output logic             busy,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               grant0;
    logic               grant1;
    logic [WIDTH-1:0]   alu_y;

    // Under contention the channel that did not win last time is granted.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    alu_logic_core #(
        .WIDTH (WIDTH)
    ) u_alu_logic_core (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_a  : req0_a;
                    b_d          = grant1 ? req1_b  : req0_b;
                    op_d         = grant1 ? req1_op : req0_op;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_y;
                rsp_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (rsp_id_q) begin
                        cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        cnt0_d = cnt0_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    always_comb begin
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        rsp_data  = rsp_data_q;
        rsp_id    = rsp_id_q;
        done_cnt0 = cnt0_q;
        done_cnt1 = cnt1_q;
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a default instance plus a CNT_W=2
// instance on the same stimulus to observe counter wrap.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;

    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0] rsp_data;
    logic [7:0] done_cnt0, done_cnt1;

    logic       n_req0_ready, n_req1_ready, n_rsp_valid, n_rsp_id, n_busy;
    logic [3:0] n_rsp_data;
    logic [1:0] n_done_cnt0, n_done_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    alu_share_ctrl #(.WIDTH(4), .CNT_W(2)) u_dut_narrow (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(n_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(n_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(n_rsp_data),
        .rsp_id(n_rsp_id), .busy(n_busy), .done_cnt0(n_done_cnt0), .done_cnt1(n_done_cnt1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = OP_AND;
        req1_a = '0; req1_b = '0; req1_op = OP_AND;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One request on channel ch with rsp_ready high; checks EXEC latency and result.
    task automatic do_op(input logic ch, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [3:0] exp, input string nm);
        logic rdy;
        int   waited;
        @(negedge clk);
        if (ch) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        rdy = ch ? req1_ready : req0_ready;
        waited = 0;
        while (!rdy && waited < 10) begin
            @(negedge clk); #1;
            rdy = ch ? req1_ready : req0_ready;
            waited++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL %s_grant: ready=%b required 1 within 10 cycles", nm, rdy);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Scramble inputs: result must come from the captured operands.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req0_op = ~op;
        req1_a = ~a; req1_b = ~b; req1_op = ~op;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_exec: busy=%b rsp_valid=%b required busy=1 rsp_valid=0",
                     nm, busy, rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp || rsp_id !== ch) begin
            errors++;
            $display("FAIL %s_rsp: valid=%b data=%b id=%b required valid=1 data=%b id=%b",
                     nm, rsp_valid, rsp_data, rsp_id, exp, ch);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b rsp_valid=%b required 0 0", nm, busy, rsp_valid);
        end
    endtask

    task automatic test_reset();
        req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_op = OP_AND;
        req1_a = '0; req1_b = '0; req1_op = OP_AND;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 4'b0000 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b valid=%b data=%b id=%b required 0 0 0000 0",
                     busy, rsp_valid, rsp_data, rsp_id);
        end
        checks++;
        if (done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: cnt0=%0d cnt1=%0d required 0 0", done_cnt0, done_cnt1);
        end
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: r0=%b r1=%b required 1 0", req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        do_op(1'b0, 4'b1100, 4'b1010, OP_AND, 4'b1000, "single_and");
        checks++;
        if (done_cnt0 !== 8'd1 || done_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL single_cnt: cnt0=%0d cnt1=%0d required 1 0", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_opcodes();
        do_op(1'b1, 4'b0110, 4'b0011, OP_AND,  4'b0010, "ch1_and");
        do_op(1'b1, 4'b0110, 4'b0011, OP_OR,   4'b0111, "ch1_or");
        do_op(1'b1, 4'b0110, 4'b0011, OP_XOR,  4'b0101, "ch1_xor");
        do_op(1'b1, 4'b0110, 4'b0011, OP_NOTA, 4'b1001, "ch1_nota");
        checks++;
        if (done_cnt0 !== 8'd1 || done_cnt1 !== 8'd4) begin
            errors++;
            $display("FAIL opcodes_cnt: cnt0=%0d cnt1=%0d required 1 4", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_contention();
        int         acc_cyc[$];
        logic       acc_id[$];
        logic       rsp_ids[$];
        logic [3:0] rsp_dat[$];
        int         both = 0;
        do_reset();
        @(negedge clk);
        req0_a = 4'b1100; req0_b = 4'b1010; req0_op = OP_AND;
        req1_a = 4'b0110; req1_b = 4'b0011; req1_op = OP_XOR;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) begin
                acc_cyc.push_back(c); acc_id.push_back(1'b0);
            end else if (req1_ready) begin
                acc_cyc.push_back(c); acc_id.push_back(1'b1);
            end
            if (rsp_valid && rsp_ready) begin
                rsp_ids.push_back(rsp_id); rsp_dat.push_back(rsp_data);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL contention_one_ready: both-ready cycles=%0d required 0", both);
        end
        checks++;
        if (acc_cyc.size() != 4 || rsp_ids.size() != 4) begin
            errors++;
            $display("FAIL contention_count: accepts=%0d responses=%0d required 4 4",
                     acc_cyc.size(), rsp_ids.size());
        end
        for (int i = 0; i < acc_cyc.size() && i < 4; i++) begin
            checks++;
            if (acc_id[i] !== i[0] || acc_cyc[i] != 3 * i) begin
                errors++;
                $display("FAIL contention_grant%0d: id=%b cycle=%0d required id=%b cycle=%0d",
                         i, acc_id[i], acc_cyc[i], i[0], 3 * i);
            end
        end
        for (int i = 0; i < rsp_ids.size() && i < 4; i++) begin
            checks++;
            if (rsp_ids[i] !== i[0] || rsp_dat[i] !== (i[0] ? 4'b0101 : 4'b1000)) begin
                errors++;
                $display("FAIL contention_rsp%0d: id=%b data=%b required id=%b data=%b",
                         i, rsp_ids[i], rsp_dat[i], i[0], i[0] ? 4'b0101 : 4'b1000);
            end
        end
        checks++;
        if (done_cnt0 !== 8'd2 || done_cnt1 !== 8'd2) begin
            errors++;
            $display("FAIL contention_cnt: cnt0=%0d cnt1=%0d required 2 2", done_cnt0, done_cnt1);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'b0101; req0_b = 4'b0011; req0_op = OP_OR;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: req0_ready=%b required 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'b0111 || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%b id=%b r0=%b r1=%b busy=%b required 1 0111 0 0 0 1",
                         i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready, busy);
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt0 !== 8'd1) begin
            errors++;
            $display("FAIL bp_release: busy=%b valid=%b cnt0=%0d required 0 0 1",
                     busy, rsp_valid, done_cnt0);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        do_reset();
        do_op(1'b1, 4'b1111, 4'b0000, OP_OR, 4'b1111, "pre_reset");
        checks++;
        if (done_cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL midrst_pre_cnt: cnt1=%0d required 1", done_cnt1);
        end
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 4'b1010; req1_b = 4'b0101; req1_op = OP_XOR;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_exec: busy=%b required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0 ||
            rsp_data !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: busy=%b valid=%b cnt0=%0d cnt1=%0d data=%b required 0 0 0 0 0000",
                     busy, rsp_valid, done_cnt0, done_cnt1, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || done_cnt1 !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: rsp_seen=%b cnt1=%0d busy=%b required 0 0 0",
                     seen, done_cnt1, busy);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, 4'b1010, 4'b0110, OP_XOR, 4'b1100, "wrap");
        end
        checks++;
        if (done_cnt0 !== 8'd5) begin
            errors++;
            $display("FAIL wrap_wide: cnt0=%0d required 5", done_cnt0);
        end
        checks++;
        if (n_done_cnt0 !== 2'd1) begin
            errors++;
            $display("FAIL wrap_narrow: cnt0=%0d required 1", n_done_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_opcodes();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
